sr04_multi_ranger: RTL and testbench

Parametrised successor to the single-channel SR04 ranging controller. It drives NUM_CH HC-SR04 sensors in round-robin order, one channel at a time, so that echoes cannot cross-talk. Each channel's echo width is converted to centimetres by integer division, with saturation and timeout detection. The block sits between the control unit's sensor-start command (button C / UART 'c') and the display/report path, replacing the single SR04 controller in Top.

---
 rtl/sr04_multi_ranger.sv | 240 ++++++++++++++++++++++++
 tb/tb_sr04_multi_ranger.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_multi_ranger.sv
// sr04_multi_ranger: round-robin controller for NUM_CH HC-SR04 ultrasonic sensors.
// Only one channel is triggered and measured at a time. The echo width is
// converted to whole centimetres using a us sub-counter. Results saturate at
// MAX_CM, and an echo that never rises or never falls gives a timeout result.
module sr04_multi_ranger #(
   parameter int NUM_CH     = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int TRIG_US    = 10,
   parameter int US_PER_CM  = 58,
   parameter int MAX_CM     = 400,
   parameter int TIMEOUT_US = 30_000,
   parameter int GAP_US     = 60_000,
   parameter int DW         = 9
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iStart,
   input  logic                 iContinuous,
   input  logic [NUM_CH-1:0]    iChMask,
   input  logic [NUM_CH-1:0]    iEcho,
   output logic [NUM_CH-1:0]    oTrig,
   output logic [NUM_CH*DW-1:0] oDistCm,
   output logic [NUM_CH-1:0]    oValid,
   output logic [NUM_CH-1:0]    oTimeout,
   output logic                 oBusy,
   output logic [2:0]           oCurCh,
   output logic                 oDone
);

   localparam int CYC     = CLK_HZ / 1_000_000;
   localparam int DIVW    = (CYC > 1) ? $clog2(CYC) : 1;
   localparam int T1      = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
   localparam int USMAX   = (T1 > TRIG_US) ? T1 : TRIG_US;
   localparam int USW     = $clog2(USMAX + 1);
   localparam int SUBW    = $clog2(US_PER_CM + 1);
   // The cycle in which the rise is seen already belongs to the echo, so the
   // MEASURE divider starts one cycle ahead.
   localparam logic [DIVW-1:0] DIV_PRE = DIVW'((CYC > 1) ? 1 : 0);

   typedef enum logic [2:0] {
      IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, GAP, FINISH
   } state_t;

   state_t                   state;
   logic [NUM_CH-1:0]        echoMeta, echoSync;
   logic [NUM_CH-1:0]        mask;
   logic [3:0]               scanPtr;
   logic [DIVW-1:0]          divCnt;
   logic [USW-1:0]           usCnt;
   logic [SUBW-1:0]          subCnt;
   logic [DW-1:0]            cmCnt;
   logic [NUM_CH-1:0][DW-1:0] distR;

   logic                     usTick;
   logic                     curEcho;
   logic                     selFound;
   logic [2:0]               selCh;
   logic [NUM_CH-1:0]        selHot;

   assign oDistCm = distR;
   assign usTick  = (divCnt == DIVW'(CYC - 1));

   // Two-flop synchroniser on every raw echo line
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         echoMeta <= '0;
         echoSync <= '0;
      end else begin
         echoMeta <= iEcho;
         echoSync <= echoMeta;
      end
   end

   // Synchronised echo of the channel under measurement; all others are ignored
   always_comb begin
      curEcho = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
         if (3'(k) == oCurCh) curEcho = echoSync[k];
   end

   // Lowest enabled channel at or above the scan pointer
   always_comb begin
      selFound = 1'b0;
      selCh    = '0;
      selHot   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (mask[k] && (4'(k) >= scanPtr)) begin
            selFound = 1'b1;
            selCh    = 3'(k);
         end
      end
      for (int k = 0; k < NUM_CH; k++)
         selHot[k] = selFound && (3'(k) == selCh);
   end

   // Scan FSM with its us timer, cm counter and per-channel result registers
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state    <= IDLE;
         mask     <= '0;
         scanPtr  <= '0;
         divCnt   <= '0;
         usCnt    <= '0;
         subCnt   <= '0;
         cmCnt    <= '0;
         distR    <= '0;
         oTrig    <= '0;
         oValid   <= '0;
         oTimeout <= '0;
         oBusy    <= 1'b0;
         oCurCh   <= '0;
         oDone    <= 1'b0;
      end else begin
         oDone <= 1'b0;
         // The us timer runs freely; every state change below restarts it
         if (usTick) begin
            divCnt <= '0;
            usCnt  <= usCnt + 1'b1;
         end else begin
            divCnt <= divCnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (iStart) begin
                  if (iChMask != '0) begin
                     mask    <= iChMask;
                     oBusy   <= 1'b1;
                     scanPtr <= '0;
                     state   <= SELECT;
                     divCnt  <= '0;
                     usCnt   <= '0;
                  end else begin
                     oDone <= 1'b1;
                  end
               end
            end

            SELECT: begin
               divCnt <= '0;
               usCnt  <= '0;
               if (selFound) begin
                  oCurCh <= selCh;
                  oTrig  <= selHot;
                  state  <= TRIG;
               end else begin
                  state <= FINISH;
               end
            end

            TRIG: begin
               if (usTick && usCnt == USW'(TRIG_US - 1)) begin
                  oTrig  <= '0;
                  state  <= WAIT_RISE;
                  divCnt <= '0;
                  usCnt  <= '0;
               end
            end

            WAIT_RISE: begin
               // A level test: an echo that is already high counts as a rise
               if (curEcho) begin
                  state  <= MEASURE;
                  divCnt <= DIV_PRE;
                  usCnt  <= '0;
                  subCnt <= '0;
                  cmCnt  <= '0;
               end else if (usTick && usCnt == USW'(TIMEOUT_US - 1)) begin
                  for (int k = 0; k < NUM_CH; k++)
                     if (3'(k) == oCurCh) begin
                        distR[k]    <= DW'(MAX_CM);
                        oValid[k]   <= 1'b0;
                        oTimeout[k] <= 1'b1;
                     end
                  state  <= GAP;
                  divCnt <= '0;
                  usCnt  <= '0;
               end
            end

            MEASURE: begin
               if (!curEcho) begin
                  for (int k = 0; k < NUM_CH; k++)
                     if (3'(k) == oCurCh) begin
                        distR[k]    <= cmCnt;
                        oValid[k]   <= 1'b1;
                        oTimeout[k] <= 1'b0;
                     end
                  state  <= GAP;
                  divCnt <= '0;
                  usCnt  <= '0;
               end else if (usTick && usCnt == USW'(TIMEOUT_US - 1)) begin
                  for (int k = 0; k < NUM_CH; k++)
                     if (3'(k) == oCurCh) begin
                        distR[k]    <= DW'(MAX_CM);
                        oValid[k]   <= 1'b0;
                        oTimeout[k] <= 1'b1;
                     end
                  state  <= GAP;
                  divCnt <= '0;
                  usCnt  <= '0;
               end else if (usTick) begin
                  if (subCnt == SUBW'(US_PER_CM - 1)) begin
                     subCnt <= '0;
                     if (cmCnt < DW'(MAX_CM)) cmCnt <= cmCnt + 1'b1;
                  end else begin
                     subCnt <= subCnt + 1'b1;
                  end
               end
            end

            GAP: begin
               if (usTick && usCnt == USW'(GAP_US - 1)) begin
                  scanPtr <= {1'b0, oCurCh} + 4'd1;
                  state   <= SELECT;
                  divCnt  <= '0;
                  usCnt   <= '0;
               end
            end

            FINISH: begin
               oDone   <= 1'b1;
               scanPtr <= '0;
               divCnt  <= '0;
               usCnt   <= '0;
               if (iContinuous) begin
                  mask  <= iChMask;
                  state <= SELECT;
               end else begin
                  oBusy <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr04_multi_ranger.sv
// Bench for sr04_multi_ranger. The clock is scaled to 2 cycles/us and MAX_CM to 40,
// which keeps saturation and timeout reachable in a short run. An echo generator
// answers each trigger with a pulse whose delay and width (in cycles) are chosen
// per channel. The expected result follows from the pulse width in plain arithmetic.
`timescale 1ns/1ps
module tb_sr04_multi_ranger;

   localparam int NCH   = 4;
   localparam int DW    = 9;
   localparam int CYC   = 2;
   localparam int UPC   = 58;
   localparam int MAXCM = 40;
   localparam int TOUS  = 3000;
   localparam int GAPUS = 200;
   localparam int TRGUS = 10;

   logic                iClk = 1'b0;
   logic                iRst, iStart, iContinuous;
   logic [NCH-1:0]      iChMask, iEcho, oTrig, oValid, oTimeout;
   logic [NCH*DW-1:0]   oDistCm;
   logic                oBusy, oDone;
   logic [2:0]          oCurCh;

   logic [NCH-1:0]      echoGen   = '0;
   logic [NCH-1:0]      echoNoise = '0;
   assign iEcho = echoGen | echoNoise;

   int echoD[NCH] = '{default: 20};
   int echoW[NCH] = '{default: 0};

   int vectors = 0, miscompares = 0;
   int expDist[NCH] = '{default: 0};
   logic [NCH-1:0] expValid = '0, expTo = '0;

   // Cumulative activity, read by the test sequence as before/after deltas
   int doneCnt = 0, busyCyc = 0, multiTrig = 0;
   int trigCyc[NCH] = '{default: 0};
   int curLen[NCH]  = '{default: 0};
   int lastLen[NCH] = '{default: 0};

   sr04_multi_ranger #(
      .NUM_CH(NCH), .CLK_HZ(CYC * 1_000_000), .TRIG_US(TRGUS), .US_PER_CM(UPC),
      .MAX_CM(MAXCM), .TIMEOUT_US(TOUS), .GAP_US(GAPUS), .DW(DW)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iContinuous(iContinuous),
      .iChMask(iChMask), .iEcho(iEcho), .oTrig(oTrig), .oDistCm(oDistCm),
      .oValid(oValid), .oTimeout(oTimeout), .oBusy(oBusy), .oCurCh(oCurCh),
      .oDone(oDone)
   );

   always #250 iClk = ~iClk;

   always @(negedge iClk) begin
      if (oDone) doneCnt++;
      if (oBusy) busyCyc++;
      if ($countones(oTrig) > 1) multiTrig++;
      for (int k = 0; k < NCH; k++) begin
         if (oTrig[k]) begin
            trigCyc[k]++;
            curLen[k]++;
         end else begin
            if (curLen[k] != 0) lastLen[k] = curLen[k];
            curLen[k] = 0;
         end
      end
   end

   // Sensor model: on a trigger fall, wait echoD cycles, then hold echo for echoW cycles
   initial begin : echo_gen
      logic [NCH-1:0] prevTrig;
      int hit;
      prevTrig = '0;
      forever begin
         @(negedge iClk);
         hit = -1;
         for (int k = 0; k < NCH; k++)
            if (prevTrig[k] && !oTrig[k]) hit = k;
         prevTrig = oTrig;
         if (hit >= 0 && echoW[hit] != 0) begin
            repeat (echoD[hit]) @(negedge iClk);
            echoGen[hit] = 1'b1;
            repeat (echoW[hit]) @(negedge iClk);
            echoGen[hit] = 1'b0;
            prevTrig = oTrig;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected result of one channel from its echo width in cycles
   task automatic modelRes(input int k);
      int w, us;
      w = echoW[k];
      if (w == 0 || w >= TOUS * CYC) begin
         expDist[k] = MAXCM; expValid[k] = 1'b0; expTo[k] = 1'b1;
      end else begin
         us = w / CYC;
         expDist[k] = (us / UPC > MAXCM) ? MAXCM : us / UPC;
         expValid[k] = 1'b1; expTo[k] = 1'b0;
      end
   endtask

   task automatic chkAll(input string tag);
      for (int k = 0; k < NCH; k++)
         chk($sformatf("%s_dist%0d", tag, k), 64'(oDistCm[k*DW +: DW]), 64'(expDist[k]));
      chk({tag, "_valid"}, 64'(oValid), 64'(expValid));
      chk({tag, "_timeout"}, 64'(oTimeout), 64'(expTo));
   endtask

   task automatic pulseStart();
      @(negedge iClk); iStart = 1'b1;
      @(negedge iClk); iStart = 1'b0;
   endtask

   task automatic waitDone(input int budget, input string tag, output int cyc);
      cyc = 0;
      while (!oDone && cyc < budget) begin
         @(negedge iClk);
         cyc++;
      end
      chk({tag, "_done_seen"}, 64'(oDone), 64'd1);
   endtask

   task automatic runScan(input logic [NCH-1:0] m, input string tag, output int lat);
      int d0, mt0;
      int tc[NCH];
      d0 = doneCnt; mt0 = multiTrig;
      for (int k = 0; k < NCH; k++) tc[k] = trigCyc[k];
      iChMask = m;
      pulseStart();
      waitDone(60000, tag, lat);
      repeat (5) @(negedge iClk);
      for (int k = 0; k < NCH; k++) if (m[k]) modelRes(k);
      chkAll(tag);
      chk({tag, "_done_once"}, 64'(doneCnt - d0), 64'd1);
      chk({tag, "_one_hot"}, 64'(multiTrig - mt0), 64'd0);
      for (int k = 0; k < NCH; k++)
         chk($sformatf("%s_trig%0d_used", tag, k), 64'((trigCyc[k] - tc[k]) != 0), 64'(m[k]));
      chk({tag, "_idle"}, 64'(oBusy), 64'd0);
   endtask

   task automatic rndEcho(input int maxW);
      for (int k = 0; k < NCH; k++) begin
         echoD[k] = $urandom_range(200, 20);
         echoW[k] = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(maxW, 1);
      end
   endtask

   initial begin : seq
      int lat, d0, b0, t0, n;
      logic [NCH-1:0] m;
      iRst = 1'b1; iStart = 1'b0; iContinuous = 1'b0; iChMask = '0;
      #1;
      chk("rst_trig", 64'(oTrig), 0);
      chk("rst_dist", 64'(oDistCm), 0);
      chk("rst_valid", 64'(oValid), 0);
      chk("rst_timeout", 64'(oTimeout), 0);
      chk("rst_busy", 64'(oBusy), 0);
      chk("rst_curch", 64'(oCurCh), 0);
      chk("rst_done", 64'(oDone), 0);
      repeat (3) @(negedge iClk);
      iRst = 1'b0;

      // Two-channel scan: 580 us -> 10 cm, 1450 us -> 25 cm; noise on disabled ch1
      echoD[0] = 40; echoW[0] = 580 * CYC;
      echoD[2] = 60; echoW[2] = 1450 * CYC;
      echoNoise = 4'b0010;
      runScan(4'b0101, "tp", lat);
      echoNoise = '0;
      chk("tp_dist0_const", 64'(oDistCm[0 +: DW]), 64'd10);
      chk("tp_dist2_const", 64'(oDistCm[2*DW +: DW]), 64'd25);
      chk("tp_trig0_len", 64'(lastLen[0]), 64'(TRGUS * CYC));
      chk("tp_trig2_len", 64'(lastLen[2]), 64'(TRGUS * CYC));

      // No echo: timeout result and known scan length
      echoW[0] = 0;
      runScan(4'b0001, "noecho", lat);
      chk("noecho_latency", 64'(lat >= (TOUS + GAPUS + TRGUS) * CYC &&
                                lat <= (TOUS + GAPUS + TRGUS) * CYC + 20), 64'd1);

      // Echo stuck high past the timeout
      echoD[0] = 50; echoW[0] = TOUS * CYC + 600;
      runScan(4'b0001, "stuck", lat);
      repeat (800) @(negedge iClk);

      // Saturation and rounding boundaries
      echoD[0] = 30; echoW[0] = MAXCM * UPC * CYC;
      runScan(4'b0001, "sat_exact", lat);
      chk("sat_exact_const", 64'(oDistCm[0 +: DW]), 64'(MAXCM));
      echoW[0] = MAXCM * UPC * CYC - 1;
      runScan(4'b0001, "sat_minus1", lat);
      echoW[0] = MAXCM * UPC * CYC + 160;
      runScan(4'b0001, "sat_over", lat);
      echoW[0] = 57 * CYC;
      runScan(4'b0001, "us57", lat);
      chk("us57_const", 64'(oDistCm[0 +: DW]), 64'd0);

      // Randomised scans, noise on disabled channels
      for (int s = 0; s < 2; s++) begin
         rndEcho(3000);
         m = 4'($urandom_range(15, 1));
         echoNoise = 4'($urandom) & ~m;
         runScan(m, $sformatf("rnd%0d", s), lat);
         echoNoise = '0;
      end

      // Continuous mode: back-to-back scans, ignored iStart, stop after clearing
      echoD[0] = 30; echoW[0] = 232; echoD[1] = 30; echoW[1] = 348;
      iContinuous = 1'b1; iChMask = 4'b0011;
      d0 = doneCnt;
      pulseStart();
      waitDone(20000, "cont1", lat);
      @(negedge iClk);
      chk("cont1_still_busy", 64'(oBusy), 64'd1);
      pulseStart();
      waitDone(20000, "cont2", lat);
      @(negedge iClk);
      chk("cont2_still_busy", 64'(oBusy), 64'd1);
      modelRes(0); modelRes(1);
      chkAll("cont2");
      repeat (100) @(negedge iClk);
      iContinuous = 1'b0;
      waitDone(20000, "cont3", lat);
      repeat (10) @(negedge iClk);
      chk("cont_stopped", 64'(oBusy), 64'd0);
      repeat (2000) @(negedge iClk);
      chk("cont_done_count", 64'(doneCnt - d0), 64'd3);

      // Empty mask: immediate oDone, no activity
      d0 = doneCnt; b0 = busyCyc; t0 = trigCyc[0] + trigCyc[1] + trigCyc[2] + trigCyc[3];
      iChMask = '0;
      @(negedge iClk); iStart = 1'b1;
      @(negedge iClk);
      chk("mask0_done_pulse", 64'(oDone), 64'd1);
      iStart = 1'b0;
      @(negedge iClk);
      chk("mask0_done_low", 64'(oDone), 64'd0);
      repeat (20) @(negedge iClk);
      chk("mask0_done_count", 64'(doneCnt - d0), 64'd1);
      chk("mask0_no_busy", 64'(busyCyc - b0), 64'd0);
      chk("mask0_no_trig", 64'(trigCyc[0] + trigCyc[1] + trigCyc[2] + trigCyc[3] - t0), 64'd0);

      // Reset while ch1 is triggering
      echoW[1] = 0;
      iChMask = 4'b0010;
      pulseStart();
      n = 0;
      while (!oTrig[1] && n < 200) begin @(negedge iClk); n++; end
      chk("rst_mid_trig1_seen", 64'(oTrig[1]), 64'd1);
      #100 iRst = 1'b1;
      #1;
      chk("rst_mid_trig", 64'(oTrig), 0);
      chk("rst_mid_dist", 64'(oDistCm), 0);
      chk("rst_mid_valid", 64'(oValid), 0);
      chk("rst_mid_busy", 64'(oBusy), 0);
      for (int k = 0; k < NCH; k++) expDist[k] = 0;
      expValid = '0; expTo = '0;
      @(negedge iClk); @(negedge iClk);
      iRst = 1'b0;
      repeat (5) @(negedge iClk);

      // Restart after reset begins with ch0
      echoD[0] = 25; echoW[0] = 700; echoD[1] = 25; echoW[1] = 1200;
      iChMask = 4'b0011;
      pulseStart();
      n = 0;
      while (oTrig == '0 && n < 200) begin @(negedge iClk); n++; end
      chk("post_rst_first_trig", 64'(oTrig), 64'b0001);
      waitDone(20000, "post_rst", lat);
      repeat (5) @(negedge iClk);
      modelRes(0); modelRes(1);
      chkAll("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
